// File: rtl/inpkt_word_assembler.sv
// inpkt_word_assembler
// Packs the data bytes of one packet type from the parser stream into
// fixed-length little-endian words and presents them to a consumer.
//
// Handshakes:
//   Upstream side: the parser cannot stall, so `full` is the flow control.
//   A byte is written by asserting `wr_en` for one cycle, and upstream
//   asserts it only while `full`=0.
//   Output side: a word moves from producer to consumer on every rising
//   clock edge where `out_valid` and `out_ready` are both high. While
//   `out_valid` is high and `out_ready` is low, `out_word`, `out_last` and
//   `out_pkt_id` hold their values.
module inpkt_word_assembler #(
    parameter int WORD_TYPE    = 1,
    parameter int WORD_LEN     = 8,
    parameter int PKT_TYPE_MSB = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            din,
    input  logic                  wr_en,
    input  logic                  pkt_data,
    input  logic                  pkt_end,
    input  logic [PKT_TYPE_MSB:0] pkt_type,
    input  logic [15:0]           pkt_id,
    input  logic                  err_in,
    output logic                  full,
    output logic [8*WORD_LEN-1:0] out_word,
    output logic                  out_last,
    output logic [15:0]           out_pkt_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_overflow,
    output logic                  err
);

    localparam int CNT_W = $clog2(WORD_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);
    localparam logic [PKT_TYPE_MSB:0] TYPE_SEL = WORD_TYPE[PKT_TYPE_MSB:0];

    // Assembly register
    logic [8*WORD_LEN-1:0] asm_word;
    logic [CNT_W-1:0]      cnt;
    logic                  asm_last;
    logic [15:0]           asm_id;
    logic                  asm_full;

    logic type_match;
    logic wanted_byte;
    logic byte_acc;
    logic xfer;

    assign type_match  = (pkt_type == TYPE_SEL);
    assign wanted_byte = wr_en & pkt_data & type_match;
    // `full` already includes `err`, so this also blocks bytes after an error.
    assign byte_acc    = wanted_byte & ~full;
    // The output register is free when empty or when its word leaves this edge.
    assign xfer        = asm_full & (~out_valid | out_ready);

    // Both terms are flops, so `full` has no combinational path from out_ready.
    assign full = asm_full | err;

    // Assembly stage: collect accepted bytes, close the word on length or packet end.
    // byte_acc needs ~asm_full and xfer needs asm_full, so they never coincide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            asm_word <= '0;
            cnt      <= '0;
            asm_last <= 1'b0;
            asm_id   <= '0;
            asm_full <= 1'b0;
        end else if (xfer) begin
            asm_word <= '0;
            cnt      <= '0;
            asm_full <= 1'b0;
        end else if (byte_acc) begin
            for (int i = 0; i < WORD_LEN; i++) begin
                if (cnt == CNT_W'(i)) begin
                    asm_word[8*i +: 8] <= din;
                end
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == '0) begin
                asm_id <= pkt_id;
            end
            if (cnt == CNT_LAST || pkt_end) begin
                asm_full <= 1'b1;
                asm_last <= pkt_end;
            end
        end
    end

    // Output stage: load a finished word, or retire the current one on handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_word   <= '0;
            out_last   <= 1'b0;
            out_pkt_id <= '0;
            out_valid  <= 1'b0;
        end else if (xfer) begin
            out_word   <= asm_word;
            out_last   <= asm_last;
            out_pkt_id <= asm_id;
            out_valid  <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err          <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (err_in) begin
                err <= 1'b1;
            end
            if (wanted_byte && full) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/inpkt_word_assembler.md
# inpkt_word_assembler

Downstream consumer of the input-packet header parser. It takes the parsed byte stream, keeps only data bytes of one packet type, and packs them into fixed-length little-endian words (candidate keys) for the DES-crypt word generator. It presents the words on a valid/ready interface and raises `full` so upstream gates `wr_en`, since the parser itself cannot stall.

## Interface
Parameters:
- `WORD_TYPE`, 1: packet type whose data bytes are assembled; other types' data bytes are discarded.
- `WORD_LEN`, 8: bytes per output word, 1..16.
- `PKT_TYPE_MSB`, 2: MSB of `pkt_type`, same as the parser's.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: clock.
- `RST` in 1: asynchronous active-high reset.
- `din` in 8: byte from the parser's input stream.
- `wr_en` in 1: byte valid. Upstream drives it only when `full`=0.
- `pkt_data` in 1: the current byte is packet data.
- `pkt_end` in 1: the current byte is the last data byte.
- `pkt_type` in PKT_TYPE_MSB+1: current packet type.
- `pkt_id` in 16: current packet id.
- `err_in` in 1: OR of the parser's error flags.
- `full` out 1: assembly register occupied; upstream must not write.
- `out_word` out 8*WORD_LEN: assembled word; the first byte is in `[7:0]`.
- `out_last` out 1: this word ends its packet.
- `out_pkt_id` out 16: id of the packet the word came from.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word.
- `err_overflow` out 1: sticky; a write arrived while `full`=1.
- `err` out 1: sticky; `err_in` was seen.

## Operation
- Accepted byte: `wr_en & pkt_data & pkt_type==WORD_TYPE & ~full & ~err`. All other writes are ignored. If such a write arrives while `full`=1, it also sets `err_overflow`.
- Assembly stage:
  - Holds `asm_word`, byte counter `cnt` (width clog2(WORD_LEN+1)), `asm_last`, `asm_id`, and `asm_full`.
  - An accepted byte is written to `asm_word[8*cnt +: 8]` and `cnt` increments.
  - If `cnt==WORD_LEN-1` or `pkt_end`: `asm_full`←1 and `asm_last`←`pkt_end`.
  - Any byte positions not yet written are zero. `asm_word` is cleared whenever it is transferred.
  - `asm_id` latches `pkt_id` on the first byte of each word.
- Packet shorter than, or not a multiple of, WORD_LEN: the final word is zero-padded and emitted with `out_last`=1. This is not an error.
- Output stage:
  - Transfer happens when `asm_full & (~out_valid | out_ready)`. On transfer: `out_word`←`asm_word`, `out_last`←`asm_last`, `out_pkt_id`←`asm_id`, `out_valid`←1, `asm_full`←0, `cnt`←0.
  - `out_ready & out_valid` without a transfer: `out_valid`←0.
- `full` = `asm_full | err`. This is a registered value with no combinational path from `out_ready`.
- Error path:
  - `err_in`=1 sets `err`. From then on no bytes are accepted and `full` stays 1.
  - A word already in the output register still drains. A word already in the assembly register still transfers normally.
  - Only `RST` clears `err`.
- Non-WORD_TYPE packets pass through the parser without affecting `cnt`.

## Timing
- Reset values: `full`=0, `out_valid`=0, `out_last`=0, `out_word`=0, `out_pkt_id`=0, `err_overflow`=0, `err`=0; internally `cnt`=0 and `asm_full`=0.
- Reset asserted mid-word or mid-packet: the partial word is discarded and the block restarts clean on the first edge after release.
- Latency: completing byte written at edge N → `full`=1 after N → transfer at edge N+1 if the output register is free → `out_valid`=1 after N+1.
- Throughput: one word per WORD_LEN+1 cycles when the consumer is always ready. `asm_full` costs one bubble cycle per word.
- Back-to-back packets: when `pkt_end` completes a word, the next packet's first byte may be written as soon as `full`=0.
- Simultaneous `out_ready` and transfer: the output register is overwritten in the same edge with no gap in `out_valid`.
- `out_word`, `out_last` and `out_pkt_id` are stable while `out_valid & ~out_ready`.

## Test plan
- WORD_TYPE packet of 16 bytes 0x01..0x10, `out_ready`=1 → two words: 0x0807060504030201 with `out_last`=0, then 0x100F0E0D0C0B0A09 with `out_last`=1. Both carry the packet's id. `out_valid` rises 2 cycles after each 8th byte.
- 3-byte packet 0xAA,0xBB,0xCC → one word 0x0000000000CCBBAA with `out_last`=1.
- Type-2 packet of 8 bytes followed by a WORD_TYPE packet of 8 bytes → only the second packet emits a word. `cnt` is unaffected by the first.
- `out_ready`=0 while 24 bytes are offered, with upstream honouring `full` → exactly 2 words buffered and `full`=1. Raising `out_ready` drains the words in order with no loss.
- `wr_en` forced while `full`=1 → `err_overflow`=1, the byte is dropped, and the buffered word is unchanged.
- `err_in` pulse mid-word, then `RST` mid-packet → after the pulse `err`=1 and `full` stays 1. After reset, all outputs are 0 and a fresh 8-byte packet produces one correct word.
